// File: rtl/dii_buffer_pkg.sv
// Shared helpers for DII buffers: counter-width derivation and modulo pointer increment.
// Pointers wrap at an arbitrary depth, so non-power-of-two buffers are legal.
package dii_buffer_pkg;

    function automatic int cw_of(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/dii_packet_buffer_lenfifo.sv
// Small synchronous FIFO of packet lengths; head visible one cycle after push.
// No flow control: the owner guarantees it never pushes when full or pops when empty.
module dii_packet_buffer_lenfifo
    import dii_buffer_pkg::*;
#(
    parameter int W     = 4,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = PW'(ptr_inc(int'(wr_ptr_q), DEPTH));
        if (pop)  rd_ptr_d = PW'(ptr_inc(int'(rd_ptr_q), DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/dii_packet_buffer.sv
// Circular-pointer DII flit FIFO with optional store-and-forward; 1-cycle latency, in_ready low when full.
// Define DII_PACKET_BUFFER_PKTLEN_EN to report the remaining length of the head packet.
module dii_packet_buffer
    import dii_buffer_pkg::*;
#(
    parameter  int WIDTH      = 16,
    parameter  int DEPTH      = 8,
    parameter  int FULLPACKET = 0,
    localparam int CW         = cw_of(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_first,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_first,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    level,
    output logic [CW-1:0]    packet_count,
    output logic             forced_release,
    output logic [CW-1:0]    head_packet_size
);
    localparam int            PW       = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             first;
        logic             last;
    } flit_t;

    flit_t         mem_q [DEPTH];
    flit_t         head;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] level_q, level_d;
    logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic          fr_q, fr_d;
    logic          push, pop;

    assign head      = mem_q[rd_ptr_q];
    assign out_data  = head.data;
    assign out_first = head.first;
    assign out_last  = head.last;

    always_comb begin
        in_ready = (level_q != FULL_LVL);
        // A forced release can drain an incomplete packet to empty; never offer a flit that isn't there.
        if (FULLPACKET != 0) out_valid = ((pkt_cnt_q != '0) || fr_q) && (level_q != '0);
        else                 out_valid = (level_q != '0);

        push = in_valid && in_ready;
        pop  = out_valid && out_ready;

        wr_ptr_d = push ? PW'(ptr_inc(int'(wr_ptr_q), DEPTH)) : wr_ptr_q;
        rd_ptr_d = pop  ? PW'(ptr_inc(int'(rd_ptr_q), DEPTH)) : rd_ptr_q;

        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        pkt_cnt_d = pkt_cnt_q + CW'(push && in_last) - CW'(pop && out_last);

        fr_d = 1'b0;
        if (FULLPACKET != 0)
            fr_d = (fr_q && !(pop && out_last)) || ((level_d == FULL_LVL) && (pkt_cnt_d == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            pkt_cnt_q <= '0;
            fr_q      <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            pkt_cnt_q <= pkt_cnt_d;
            fr_q      <= fr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{data: in_data, first: in_first, last: in_last};
    end

    assign level          = level_q;
    assign packet_count   = pkt_cnt_q;
    assign forced_release = fr_q;

`ifdef DII_PACKET_BUFFER_PKTLEN_EN
    logic [CW-1:0] in_cnt_q, in_cnt_d;
    logic [CW-1:0] head_pop_q, head_pop_d;
    logic [CW-1:0] len_head;

    // in_cnt counts flits already accepted of the packet being written; head_pop those already sent.
    always_comb begin
        in_cnt_d   = in_cnt_q;
        head_pop_d = head_pop_q;
        if (push) in_cnt_d   = in_last  ? '0 : in_cnt_q + 1'b1;
        if (pop)  head_pop_d = out_last ? '0 : head_pop_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt_q   <= '0;
            head_pop_q <= '0;
        end else begin
            in_cnt_q   <= in_cnt_d;
            head_pop_q <= head_pop_d;
        end
    end

    dii_packet_buffer_lenfifo #(
        .W     (CW),
        .DEPTH (DEPTH)
    ) u_lenfifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push && in_last),
        .push_data (in_cnt_q + 1'b1),
        .pop       (pop && out_last),
        .head_data (len_head)
    );

    assign head_packet_size = (pkt_cnt_q != '0) ? (len_head - head_pop_q) : '0;
`else
    assign head_packet_size = '0;
`endif

endmodule

// File: tb/tb_dii_packet_buffer.sv
// Three buffer configurations (D5/stream, D8/store-and-forward, D4/store-and-forward) against a queue model.
module tb_dii_packet_buffer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    localparam logic [2:0][7:0] DEPV = {8'd4, 8'd8, 8'd5};
    localparam logic [2:0]      FPV  = 3'b110;
`ifdef DII_PACKET_BUFFER_PKTLEN_EN
    localparam bit PKTLEN = 1'b1;
`else
    localparam bit PKTLEN = 1'b0;
`endif

    logic [15:0] in_data [3];
    logic        in_first [3], in_last [3], in_valid [3], out_ready [3];
    logic [15:0] out_data [3];
    logic        out_first [3], out_last [3], out_valid [3], in_ready [3], fr_a [3];
    logic [7:0]  level_a [3], pc_a [3], hs_a [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int D   = int'(DEPV[g]);
        localparam int CWI = $clog2(D + 1);
        logic [CWI-1:0] lv, pc, hs;
        dii_packet_buffer #(
            .WIDTH      (16),
            .DEPTH      (D),
            .FULLPACKET (int'(FPV[g]))
        ) u_dut (
            .clk              (clk),
            .rst              (rst),
            .in_data          (in_data[g]),
            .in_first         (in_first[g]),
            .in_last          (in_last[g]),
            .in_valid         (in_valid[g]),
            .in_ready         (in_ready[g]),
            .out_data         (out_data[g]),
            .out_first        (out_first[g]),
            .out_last         (out_last[g]),
            .out_valid        (out_valid[g]),
            .out_ready        (out_ready[g]),
            .level            (lv),
            .packet_count     (pc),
            .forced_release   (fr_a[g]),
            .head_packet_size (hs)
        );
        assign level_a[g] = 8'(lv);
        assign pc_a[g]    = 8'(pc);
        assign hs_a[g]    = 8'(hs);
    end

    int nvec = 0;
    int nerr = 0;

    // Reference model: a flit queue per instance plus a list of completed packet lengths.
    typedef struct {
        logic [15:0] d;
        logic        f;
        logic        l;
    } mflit_t;
    mflit_t mq [3][$];
    int     mlens [3][$];
    int     mhp [3];
    int     mcnt [3];
    bit     mfr [3];

    function automatic int dep(input int i);
        return int'(DEPV[i]);
    endfunction

    function automatic int mpc(input int i);
        int n = 0;
        for (int k = 0; k < mq[i].size(); k++) if (mq[i][k].l) n++;
        return n;
    endfunction

    function automatic bit mvld(input int i);
        if (FPV[i]) return (mpc(i) != 0 || mfr[i]) && mq[i].size() != 0;
        return mq[i].size() != 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            int e_hs = 0;
            if (PKTLEN && mpc(i) != 0)
                e_hs = (mlens[i][0] - mhp[i]) & ((1 << $clog2(dep(i) + 1)) - 1);
            chk($sformatf("i%0d level", i), 32'(level_a[i]), mq[i].size());
            chk($sformatf("i%0d packet_count", i), 32'(pc_a[i]), mpc(i));
            chk($sformatf("i%0d in_ready", i), 32'(in_ready[i]), 32'(mq[i].size() != dep(i)));
            chk($sformatf("i%0d out_valid", i), 32'(out_valid[i]), 32'(mvld(i)));
            chk($sformatf("i%0d forced_release", i), 32'(fr_a[i]), 32'(mfr[i]));
            chk($sformatf("i%0d head_packet_size", i), 32'(hs_a[i]), e_hs);
            if (mvld(i)) begin
                chk($sformatf("i%0d out_data", i), 32'(out_data[i]), 32'(mq[i][0].d));
                chk($sformatf("i%0d out_first", i), 32'(out_first[i]), 32'(mq[i][0].f));
                chk($sformatf("i%0d out_last", i), 32'(out_last[i]), 32'(mq[i][0].l));
            end
        end
    endtask

    task automatic model_step(input int i);
        bit rdy   = mq[i].size() != dep(i);
        bit vld   = mvld(i);
        bit push  = in_valid[i] && rdy;
        bit pop   = vld && out_ready[i];
        bit plast = 1'b0;
        if (pop) begin
            plast = mq[i][0].l;
            void'(mq[i].pop_front());
            if (plast) begin
                void'(mlens[i].pop_front());
                mhp[i] = 0;
            end else begin
                mhp[i]++;
            end
        end
        if (push) begin
            mq[i].push_back('{d: in_data[i], f: in_first[i], l: in_last[i]});
            mcnt[i]++;
            if (in_last[i]) begin
                mlens[i].push_back(mcnt[i]);
                mcnt[i] = 0;
            end
        end
        mfr[i] = FPV[i] && ((mfr[i] && !plast) || (mq[i].size() == dep(i) && mpc(i) == 0));
    endtask

    task automatic cycle();
        for (int i = 0; i < 3; i++) model_step(i);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input int i, input logic v, input logic [15:0] d, input logic f, input logic l);
        in_valid[i] = v;
        in_data[i]  = d;
        in_first[i] = f;
        in_last[i]  = l;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mq[i].delete();
            mlens[i].delete();
            mhp[i]  = 0;
            mcnt[i] = 0;
            mfr[i]  = 1'b0;
        end
        check_all();
    endtask

    typedef struct {
        bit          v;
        logic [15:0] d;
        bit          f;
        bit          l;
        bit          rdy;
        int          lvl;
        int          pc;
        bit          irdy;
        bit          ovld;
        logic [15:0] odat;
    } vec_t;

    function automatic vec_t mk(bit v, logic [15:0] d, bit f, bit l, bit rdy,
                                int lvl, int pc, bit irdy, bit ovld, logic [15:0] odat);
        vec_t t;
        t.v = v; t.d = d; t.f = f; t.l = l; t.rdy = rdy;
        t.lvl = lvl; t.pc = pc; t.irdy = irdy; t.ovld = ovld; t.odat = odat;
        return t;
    endfunction

    initial begin
        vec_t        tv [13];
        logic [15:0] got [$];
        int          idx;
        bit          willpush;
        int          rdy_pct;

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(i, 1'b0, 16'h0, 1'b0, 1'b0);
            out_ready[i] = 1'b0;
        end
        @(negedge clk);
        do_reset();

        // Stream mode, DEPTH=5: fill to full, drain across the pointer wrap, then one more flit.
        for (int k = 0; k < 5; k++)
            tv[k] = mk(1'b1, 16'hA000 + 16'(k), k == 0, k == 4, 1'b0, k, 0, 1'b1, k > 0, 16'hA000);
        tv[5]  = mk(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 5, 1, 1'b0, 1'b1, 16'hA000);
        tv[6]  = mk(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 4, 1, 1'b1, 1'b1, 16'hA001);
        tv[7]  = mk(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 3, 1, 1'b1, 1'b1, 16'hA002);
        tv[8]  = mk(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 2, 1, 1'b1, 1'b1, 16'hA003);
        tv[9]  = mk(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1, 1, 1'b1, 1'b1, 16'hA004);
        tv[10] = mk(1'b1, 16'hB000, 1'b1, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 16'h0);
        tv[11] = mk(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1, 1, 1'b1, 1'b1, 16'hB000);
        tv[12] = mk(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 16'h0);
        for (int k = 0; k < 13; k++) begin
            drive(0, tv[k].v, tv[k].d, tv[k].f, tv[k].l);
            out_ready[0] = tv[k].rdy;
            chk($sformatf("t1[%0d] level", k), 32'(level_a[0]), tv[k].lvl);
            chk($sformatf("t1[%0d] packet_count", k), 32'(pc_a[0]), tv[k].pc);
            chk($sformatf("t1[%0d] in_ready", k), 32'(in_ready[0]), 32'(tv[k].irdy));
            chk($sformatf("t1[%0d] out_valid", k), 32'(out_valid[0]), 32'(tv[k].ovld));
            if (tv[k].ovld) chk($sformatf("t1[%0d] out_data", k), 32'(out_data[0]), 32'(tv[k].odat));
            cycle();
        end

        // Store-and-forward, DEPTH=8: nothing offered until the last flit is in.
        out_ready[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1, 1'b1, 16'hC000 + 16'(k), k == 0, k == 2);
            cycle();
            chk($sformatf("t2 out_valid after push %0d", k), 32'(out_valid[1]), 32'(k == 2));
        end
        drive(1, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t2 out_valid beat %0d", k), 32'(out_valid[1]), 32'd1);
            chk($sformatf("t2 out_data beat %0d", k), 32'(out_data[1]), 32'h0000C000 + 32'(k));
            cycle();
        end
        chk("t2 out_valid drained", 32'(out_valid[1]), 32'd0);
        out_ready[1] = 1'b0;

        // Store-and-forward, DEPTH=4: a 6-flit packet needs the forced release.
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t3 forced_release before push %0d", k), 32'(fr_a[2]), 32'd0);
            drive(2, 1'b1, 16'hD000 + 16'(k), k == 0, 1'b0);
            cycle();
        end
        chk("t3 forced_release full", 32'(fr_a[2]), 32'd1);
        chk("t3 out_valid full", 32'(out_valid[2]), 32'd1);
        chk("t3 in_ready full", 32'(in_ready[2]), 32'd0);
        out_ready[2] = 1'b1;
        idx = 4;
        for (int c = 0; c < 40 && got.size() < 6; c++) begin
            if (idx < 6) drive(2, 1'b1, 16'hD000 + 16'(idx), 1'b0, idx == 5);
            else         drive(2, 1'b0, 16'h0, 1'b0, 1'b0);
            if (out_valid[2] && out_ready[2]) got.push_back(out_data[2]);
            willpush = in_valid[2] && in_ready[2];
            cycle();
            if (willpush) idx++;
        end
        chk("t3 flits out", got.size(), 6);
        for (int k = 0; k < got.size(); k++)
            chk($sformatf("t3 flit %0d", k), 32'(got[k]), 32'h0000D000 + 32'(k));
        chk("t3 forced_release after last", 32'(fr_a[2]), 32'd0);
        chk("t3 level drained", 32'(level_a[2]), 32'd0);
        drive(2, 1'b0, 16'h0, 1'b0, 1'b0);
        out_ready[2] = 1'b0;

        // Sustained push+pop at level 2; E5(last) pushed while E3(last) pops.
        out_ready[0] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(0, 1'b1, 16'hE000 + 16'(k), k == 0, 1'b0);
            cycle();
        end
        out_ready[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(0, 1'b1, 16'hE000 + 16'(k + 2), 1'b0, (k + 2 == 3) || (k + 2 == 5));
            chk($sformatf("t4 level %0d", k), 32'(level_a[0]), 32'd2);
            chk($sformatf("t4 out_data %0d", k), 32'(out_data[0]), 32'h0000E000 + 32'(k));
            if (k == 3) chk("t4 packet_count before", 32'(pc_a[0]), 32'd1);
            cycle();
            if (k == 3) chk("t4 packet_count after", 32'(pc_a[0]), 32'd1);
        end
        drive(0, 1'b0, 16'h0, 1'b0, 1'b0);
        repeat (3) cycle();
        out_ready[0] = 1'b0;

        // Head packet length: packets of 2 and 3 flits.
        for (int k = 0; k < 5; k++) begin
            drive(1, 1'b1, 16'hF000 + 16'(k), (k == 0) || (k == 2), (k == 1) || (k == 4));
            cycle();
        end
        drive(1, 1'b0, 16'h0, 1'b0, 1'b0);
        chk("t5 head size initial", 32'(hs_a[1]), PKTLEN ? 32'd2 : 32'd0);
        out_ready[1] = 1'b1;
        cycle();
        chk("t5 head size after 1 pop", 32'(hs_a[1]), PKTLEN ? 32'd1 : 32'd0);
        cycle();
        chk("t5 head size after 2 pops", 32'(hs_a[1]), PKTLEN ? 32'd3 : 32'd0);
        repeat (3) cycle();
        out_ready[1] = 1'b0;

        // Reset in the middle of a packet.
        for (int k = 0; k < 3; k++) begin
            drive(0, 1'b1, 16'h5000 + 16'(k), k == 0, 1'b0);
            cycle();
        end
        drive(0, 1'b0, 16'h0, 1'b0, 1'b0);
        chk("t6 level before reset", 32'(level_a[0]), 32'd3);
        do_reset();
        chk("t6 level", 32'(level_a[0]), 32'd0);
        chk("t6 out_valid", 32'(out_valid[0]), 32'd0);
        chk("t6 in_ready", 32'(in_ready[0]), 32'd1);
        chk("t6 packet_count", 32'(pc_a[0]), 32'd0);

        // Random traffic on all three instances; drain pressure varies by phase.
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) rdy_pct = $urandom_range(10, 95);
            for (int i = 0; i < 3; i++) begin
                drive(i, $urandom_range(0, 3) != 0, 16'($urandom),
                      1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0);
                out_ready[i] = $urandom_range(0, 99) < rdy_pct;
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
